// File: rtl/fpu_ss_instr_pkg.sv
// Instruction encodings used when exercising the offload path.
package fpu_ss_instr_pkg;

  localparam logic [31:0] FADD_S  = 32'h0020_8053;
  localparam logic [31:0] FMV_X_W = 32'hE000_82D3;
  localparam logic [31:0] FLW     = 32'h0001_2087;
  localparam logic [31:0] ADD     = 32'h0000_0033;

endpackage

// File: rtl/fpu_ss_pkg.sv
// Shared types and constants for the FPU subsystem offload path.
package fpu_ss_pkg;

  // Default budget of accepted-but-unreturned integer writebacks.
  localparam int unsigned FpuSsMaxWbOutstanding = 4;

  // Predecode request: the instruction being classified.
  typedef struct packed {
    logic [31:0] q_instr_data;
  } acc_prd_req_t;

  // Predecode response, valid in the same cycle as the request.
  typedef struct packed {
    logic       p_accept;
    logic       p_writeback;
    logic       p_is_mem_op;
    logic [2:0] p_use_rs;
  } acc_prd_rsp_t;

  // Offload issuer control states.
  typedef enum logic [1:0] {
    ISSUER_IDLE    = 2'd0,
    ISSUER_PRED    = 2'd1,
    ISSUER_ILLEGAL = 2'd2,
    ISSUER_ISSUE   = 2'd3
  } issuer_state_e;

  // Operand forwarded for rs1: the register value when used, zero otherwise.
  function automatic logic [31:0] rs1_operand(input logic use_rs1, input logic [31:0] rs1);
    return use_rs1 ? rs1 : 32'h0000_0000;
  endfunction

endpackage

// File: rtl/fpu_ss_wb_counter.sv
// Up/down counter of outstanding writebacks, saturating at 0 and MaxCount.
module fpu_ss_wb_counter #(
  parameter  int unsigned MaxCount = 4,
  localparam int unsigned CntWidth = $clog2(MaxCount + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                full_o,
  output logic                empty_o
);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  // Next count: simultaneous inc and dec cancel; both ends saturate.
  always_comb begin
    cnt_d = cnt_q;
    case ({inc_i, dec_i})
      2'b10: begin
        if (!full_o) begin
          cnt_d = cnt_q + CntWidth'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      2'b01: begin
        if (!empty_o) begin
          cnt_d = cnt_q - CntWidth'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign full_o  = (cnt_q == CntWidth'(MaxCount));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fpu_ss_wb_counter_chk.sv
// Protocol checks for the outstanding-writeback counter.
module fpu_ss_wb_counter_chk (
  input logic clk_i,
  input logic rst_i,
  input logic inc_i,
  input logic dec_i,
  input logic full_i,
  input logic empty_i
);

  // A returned result with nothing outstanding is a core-side protocol error.
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(dec_i && !inc_i && empty_i));

  // The predecode stall must keep issue from pushing the count past the budget.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(inc_i && !dec_i && full_i));

endmodule

// File: rtl/fpu_ss_offload_issuer.sv
// Core-side issuer: predecodes one instruction at a time, then flags it
// illegal or offloads it with rs1, bounding outstanding integer writebacks.
module fpu_ss_offload_issuer
  import fpu_ss_pkg::*;
#(
  parameter  int unsigned MaxWbOutstanding = FpuSsMaxWbOutstanding,
  localparam int unsigned CntWidth         = $clog2(MaxWbOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                instr_valid_i,
  output logic                instr_ready_o,
  input  logic [31:0]         instr_data_i,
  input  logic [31:0]         rs1_i,
  input  logic                rs1_valid_i,
  output acc_prd_req_t        prd_req_o,
  input  acc_prd_rsp_t        prd_rsp_i,
  output logic                q_valid_o,
  input  logic                q_ready_i,
  output logic [31:0]         q_instr_o,
  output logic [31:0]         q_rs1_o,
  output logic                q_wb_o,
  output logic                q_mem_o,
  output logic                illegal_o,
  input  logic                wb_valid_i,
  output logic [CntWidth-1:0] wb_cnt_o,
  output logic                busy_o
);

  issuer_state_e       state_q, state_d;
  logic [31:0]         instr_q, instr_d;
  logic [31:0]         rs1_q, rs1_d;
  logic                wb_q, wb_d;
  logic                mem_q, mem_d;
  logic                rs1_stall_s, wb_stall_s;
  logic                wb_inc_s, wb_full_s, wb_empty_s;
  logic [CntWidth-1:0] wb_cnt_s;
  logic [1:0]          unused_use_rs_s;

  // Only rs1 is forwarded; the other source-use flags are deliberately dropped.
  assign unused_use_rs_s = prd_rsp_i.p_use_rs[2:1];

  // The wb stall reads the registered count, so a return during a stall
  // cycle lets the instruction proceed on the following cycle.
  assign rs1_stall_s = prd_rsp_i.p_use_rs[0] & ~rs1_valid_i;
  assign wb_stall_s  = prd_rsp_i.p_writeback & wb_full_s;
  assign wb_inc_s    = (state_q == ISSUER_ISSUE) & q_ready_i & wb_q;

  // Next-state and capture logic for the issue sequence.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    rs1_d   = rs1_q;
    wb_d    = wb_q;
    mem_d   = mem_q;
    case (state_q)
      ISSUER_IDLE: begin
        if (instr_valid_i) begin
          instr_d = instr_data_i;
          state_d = ISSUER_PRED;
        end else begin
          state_d = ISSUER_IDLE;
        end
      end
      ISSUER_PRED: begin
        if (!prd_rsp_i.p_accept) begin
          state_d = ISSUER_ILLEGAL;
        end else if (rs1_stall_s || wb_stall_s) begin
          state_d = ISSUER_PRED;
        end else begin
          rs1_d   = rs1_operand(prd_rsp_i.p_use_rs[0], rs1_i);
          wb_d    = prd_rsp_i.p_writeback;
          mem_d   = prd_rsp_i.p_is_mem_op;
          state_d = ISSUER_ISSUE;
        end
      end
      ISSUER_ILLEGAL: begin
        state_d = ISSUER_IDLE;
      end
      ISSUER_ISSUE: begin
        if (q_ready_i) begin
          state_d = ISSUER_IDLE;
        end else begin
          state_d = ISSUER_ISSUE;
        end
      end
      default: begin
        state_d = ISSUER_IDLE;
      end
    endcase
  end

  // State and latched-instruction registers; reset drops any in-flight work.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ISSUER_IDLE;
      instr_q <= 32'h0000_0000;
      rs1_q   <= 32'h0000_0000;
      wb_q    <= 1'b0;
      mem_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      rs1_q   <= rs1_d;
      wb_q    <= wb_d;
      mem_q   <= mem_d;
    end
  end

  fpu_ss_wb_counter #(
    .MaxCount (MaxWbOutstanding)
  ) u_wb_counter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (wb_inc_s),
    .dec_i   (wb_valid_i),
    .cnt_o   (wb_cnt_s),
    .full_o  (wb_full_s),
    .empty_o (wb_empty_s)
  );

  fpu_ss_wb_counter_chk u_wb_counter_chk (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (wb_inc_s),
    .dec_i   (wb_valid_i),
    .full_i  (wb_full_s),
    .empty_i (wb_empty_s)
  );

  assign prd_req_o.q_instr_data = instr_q;
  assign instr_ready_o          = (state_q == ISSUER_IDLE);
  assign q_valid_o              = (state_q == ISSUER_ISSUE);
  assign illegal_o              = (state_q == ISSUER_ILLEGAL);
  assign q_instr_o              = instr_q;
  assign q_rs1_o                = rs1_q;
  assign q_wb_o                 = wb_q;
  assign q_mem_o                = mem_q;
  assign wb_cnt_o               = wb_cnt_s;
  assign busy_o                 = (state_q != ISSUER_IDLE) | ~wb_empty_s;

endmodule

// File: doc/fpu_ss_offload_issuer.md
Name: fpu_ss_offload_issuer

Overview:
Core-side initiator of the FPU subsystem predecode/offload protocol. It accepts one instruction at a time from the core decode stage, drives the predecode request, and samples the combinational predecode response. It then either flags the instruction illegal or issues it with operand rs1 on the offload channel. It counts outstanding integer writebacks so that results returning to the core never exceed a fixed budget.

Parameters:
MaxWbOutstanding, 4, maximum accepted-but-unreturned writeback instructions (1..15)
CntWidth, $clog2(MaxWbOutstanding+1), localparam, width of the writeback counter

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high; one clock, synchronous active-high reset
instr_valid_i  in  1  core offers instruction
instr_ready_o  out  1  issuer can take instruction
instr_data_i  in  32  instruction word
rs1_i  in  32  integer rs1 value from core register file
rs1_valid_i  in  1  rs1_i is current, no hazard
prd_req_o  out  acc_prd_req_t  predecode request; q_instr_data = latched instruction
prd_rsp_i  in  acc_prd_rsp_t  p_accept, p_writeback, p_is_mem_op, p_use_rs[2:0]
q_valid_o  out  1  offload request valid
q_ready_i  in  1  accelerator takes request
q_instr_o  out  32  offloaded instruction
q_rs1_o  out  32  captured rs1, or 0 when unused
q_wb_o  out  1  captured p_writeback
q_mem_o  out  1  captured p_is_mem_op
illegal_o  out  1  one-cycle pulse: instruction rejected
wb_valid_i  in  1  one integer result returned to core
wb_cnt_o  out  CntWidth  outstanding writeback count
busy_o  out  1  FSM not IDLE or wb_cnt_o != 0

Behaviour:
- Reset values: FSM=IDLE, instr_ready_o=1, q_valid_o=0, illegal_o=0, wb_cnt_o=0, busy_o=0, and all latched data zero. Reset mid-operation drops any in-flight instruction with no pulse.
- IDLE: instr_ready_o=1. On instr_valid_i, latch instr_data_i and go to PRED. instr_ready_o=0 in every other state.
- PRED: prd_req_o.q_instr_data = latch (held stable). The response is sampled in the same cycle.
  - p_accept=0 -> ILLEGAL.
  - Else stall in PRED if (p_use_rs[0] & !rs1_valid_i), or if (p_writeback & wb_cnt == MaxWbOutstanding).
  - Otherwise capture rs1_i (or 0 if p_use_rs[0]=0), p_writeback and p_is_mem_op, then go to ISSUE.
  - p_use_rs[2:1] are ignored. Only rs1 is supported.
- ILLEGAL: illegal_o=1 for exactly one cycle, then IDLE. No offload and no counter change.
- ISSUE: q_valid_o=1 with stable q_* until q_ready_i. On handshake go to IDLE. Minimum latency from instr accept to q_valid_o is 2 cycles; the next instr accept can occur 1 cycle after the handshake.
- wb counter:
  - +1 on (q_valid_o & q_ready_i & q_wb_o).
  - -1 on wb_valid_i.
  - Both in the same cycle leave it unchanged.
  - wb_valid_i at 0 with no increment holds at 0 (simulation assertion fires).
  - Increment at MaxWbOutstanding cannot occur, because PRED gates it.
- The wb stall is re-evaluated every cycle. A wb_valid_i in a stall cycle frees the slot and the issuer proceeds on the next cycle.

Decomposition:
- The FSM state enum and MaxWbOutstanding default belong in fpu_ss_pkg.
- acc_prd_req_t and acc_prd_rsp_t are already in fpu_ss_pkg.
- Instruction encodings for tests come from fpu_ss_instr_pkg.
- One natural sub-module: fpu_ss_wb_counter (up/down saturating counter with full/empty).
- The existing predecoder is instantiated only in the bench.

Test Plan:
1. FADD.S 0x00208053, q_ready_i=1 -> q_valid_o at cycle 2, q_rs1_o=0, q_wb_o=0, wb_cnt_o stays 0, instr_ready_o high again at cycle 3.
2. FMV.X.W 0xE00082D3 issued 4 times with no wb_valid_i, then a fifth -> wb_cnt_o=4, fifth stalls in PRED. One wb_valid_i -> issued next cycle, wb_cnt_o returns to 4.
3. FLW 0x00012087 with rs1_valid_i=0 for 3 cycles, rs1_i=0x1000 -> stalls 3 cycles, then q_rs1_o=0x1000, q_mem_o=1.
4. ADD 0x00000033 -> illegal_o one pulse at cycle 2, q_valid_o never asserted, back to IDLE.
5. q_ready_i low 5 cycles on FMV.X.W while wb_valid_i pulses -> q_* stable throughout. The handshake cycle coinciding with wb_valid_i leaves wb_cnt_o unchanged.
6. rst_i asserted while in ISSUE -> next cycle q_valid_o=0, wb_cnt_o=0, instr_ready_o=1.
